// File: rtl/mmc3_pkg.sv
// mmc3_pkg: shared register-select codes and counter width for the MMC3 scanline IRQ block
package mmc3_pkg;
  localparam int MMC3_CNT_W = 8;
  typedef enum logic [1:0] {
    MMC3_REG_LATCH   = 2'd0,
    MMC3_REG_RELOAD  = 2'd1,
    MMC3_REG_DISABLE = 2'd2,
    MMC3_REG_ENABLE  = 2'd3
  } mmc3_reg_e;
endpackage

// File: rtl/mmc3_scanline_irq_if.sv
// mmc3_scanline_irq_if: A12 input, mapper register write port and IRQ/counter/a12_clk outputs
// master drives a12 and register writes; slave is the IRQ block.
interface mmc3_scanline_irq_if;
  import mmc3_pkg::*;
  logic                  a12;
  logic                  reg_we;
  logic [1:0]            reg_sel;
  logic [7:0]            reg_data;
  logic                  irq_n;
  logic [MMC3_CNT_W-1:0] counter;
  logic                  a12_clk;
  modport master (output a12, reg_we, reg_sel, reg_data, input irq_n, counter, a12_clk);
  modport slave (input a12, reg_we, reg_sel, reg_data, output irq_n, counter, a12_clk);
endinterface

// File: rtl/a12_edge_filter.sv
// a12_edge_filter: synchronises raw A12 and emits one a12_clk pulse per rise preceded by A12_LOW_MIN low cycles
// Ports: m2 clock, reset sync active-high, a12 raw async input, a12_clk registered one-cycle pulse.
module a12_edge_filter #(
  parameter int A12_LOW_MIN     = 3,
  parameter int A12_SYNC_STAGES = 2
) (
  input  logic m2,
  input  logic reset,
  input  logic a12,
  output logic a12_clk
);
  logic [A12_SYNC_STAGES-1:0] sync;
  logic                       a12_s;
  logic                       a12_d;
  logic [3:0]                 low_cnt;
  logic                       rise;
  always_comb begin
    a12_s = sync[A12_SYNC_STAGES-1];
    rise  = a12_s && !a12_d && low_cnt == 4'(A12_LOW_MIN);
  end
  always_ff @(posedge m2) begin
    if (reset) begin
      sync    <= '0;
      a12_d   <= 1'b0;
      low_cnt <= 4'd0;
      a12_clk <= 1'b0;
    end else begin
      sync    <= {sync[A12_SYNC_STAGES-2:0], a12};
      a12_d   <= a12_s;
      low_cnt <= a12_s ? 4'd0 : (low_cnt == 4'(A12_LOW_MIN) ? low_cnt : low_cnt + 4'd1);
      a12_clk <= rise;
    end
  end
endmodule

// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq: MMC3 scanline counter with latch/reload/enable registers and latched IRQ
// Ports: m2 clock, reset sync active-high, bus (slave) carries a12, register writes, irq_n, counter, a12_clk.
// Optional COOLGIRL_MMC3_ALT_IRQ_EN selects old-revision IRQ: only a 1->0 decrement or a
// reload_flag reload of latch 0 raises pending.
module mmc3_scanline_irq
  import mmc3_pkg::*;
#(
  parameter int A12_LOW_MIN     = 3,
  parameter int A12_SYNC_STAGES = 2
) (
  input logic               m2,
  input logic               reset,
  mmc3_scanline_irq_if.slave bus
);
  logic [MMC3_CNT_W-1:0] cnt;
  logic [MMC3_CNT_W-1:0] latch;
  logic [MMC3_CNT_W-1:0] step_val;
  logic                  reload_flag;
  logic                  enabled;
  logic                  pending;
  logic                  a12_clk;
  logic                  zero_evt;
  logic                  wr_latch;
  logic                  wr_reload;
  logic                  wr_disable;
  logic                  wr_enable;
  a12_edge_filter #(
    .A12_LOW_MIN    (A12_LOW_MIN),
    .A12_SYNC_STAGES(A12_SYNC_STAGES)
  ) u_filter (
    .m2     (m2),
    .reset  (reset),
    .a12    (bus.a12),
    .a12_clk(a12_clk)
  );
  always_comb begin
    wr_latch   = bus.reg_we && bus.reg_sel == MMC3_REG_LATCH;
    wr_reload  = bus.reg_we && bus.reg_sel == MMC3_REG_RELOAD;
    wr_disable = bus.reg_we && bus.reg_sel == MMC3_REG_DISABLE;
    wr_enable  = bus.reg_we && bus.reg_sel == MMC3_REG_ENABLE;
    step_val   = (cnt == '0 || reload_flag) ? latch : cnt - 1'b1;
`ifdef COOLGIRL_MMC3_ALT_IRQ_EN
    zero_evt   = a12_clk && ((cnt == 8'd1 && !reload_flag) || (reload_flag && latch == '0));
`else
    zero_evt   = a12_clk && step_val == '0;
`endif
    bus.counter = cnt;
    bus.irq_n   = !pending;
    bus.a12_clk = a12_clk;
  end
  // A reload write on a step edge overrides the step's counter result, but the
  // step's zero evaluation (from the pre-write state) still feeds pending.
  always_ff @(posedge m2) begin
    if (reset) begin
      cnt         <= '0;
      latch       <= '0;
      reload_flag <= 1'b0;
      enabled     <= 1'b0;
      pending     <= 1'b0;
    end else begin
      if (a12_clk) begin
        cnt         <= step_val;
        reload_flag <= 1'b0;
      end
      if (wr_reload) begin
        cnt         <= '0;
        reload_flag <= 1'b1;
      end
      if (wr_latch) latch <= bus.reg_data;
      if (wr_disable) enabled <= 1'b0;
      if (wr_enable) enabled <= 1'b1;
      pending <= wr_disable ? 1'b0 : (pending || (zero_evt && enabled));
    end
  end
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq: directed self-checking bench for the MMC3 scanline IRQ block
module tb_mmc3_scanline_irq;
  import mmc3_pkg::*;
  logic m2;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   pulses;
  mmc3_scanline_irq_if bus ();
  mmc3_scanline_irq #(.A12_LOW_MIN(3), .A12_SYNC_STAGES(2)) dut (
    .m2   (m2),
    .reset(reset),
    .bus  (bus)
  );
  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic tick();
    @(posedge m2);
    #1;
    if (bus.a12_clk) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    bus.reg_we   = 1'b1;
    bus.reg_sel  = sel;
    bus.reg_data = data;
    tick();
    bus.reg_we   = 1'b0;
  endtask

  // a12 low for lo cycles then high for 4; the step edge is the 4th high cycle
  task automatic pulse(input int lo);
    bus.a12 = 1'b0;
    ticks(lo);
    bus.a12 = 1'b1;
    ticks(4);
  endtask

  // same as pulse, with a register write landing on the step edge
  task automatic pulse_wr(input int lo, input logic [1:0] sel, input logic [7:0] data);
    bus.a12 = 1'b0;
    ticks(lo);
    bus.a12 = 1'b1;
    ticks(3);
    wr(sel, data);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    pulses = 0;
    ticks(10);
    n_cmp++;
    if (bus.irq_n !== 1'b1) begin n_bad++; $display("FAIL reset_irq_n: got %b expected 1", bus.irq_n); end
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL reset_counter: got %0d expected 0", bus.counter); end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL reset_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_count();
    logic [7:0] exp_cnt[4];
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0};
    wr(MMC3_REG_LATCH, 8'd3);
    wr(MMC3_REG_RELOAD, 8'd0);
    wr(MMC3_REG_ENABLE, 8'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      pulse(4);
      n_cmp++;
      if (bus.counter !== exp_cnt[i]) begin n_bad++; $display("FAIL count_step%0d: got %0d expected %0d", i, bus.counter, exp_cnt[i]); end
      n_cmp++;
      if (bus.irq_n !== (i == 3 ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL count_irq%0d: got %b expected %b", i, bus.irq_n, i != 3); end
    end
    n_cmp++;
    if (pulses !== 4) begin n_bad++; $display("FAIL count_pulses: got %0d expected 4", pulses); end
    wr(MMC3_REG_DISABLE, 8'd0);
    n_cmp++;
    if (bus.irq_n !== 1'b1) begin n_bad++; $display("FAIL count_disable: got %b expected 1", bus.irq_n); end
  endtask

  task automatic test_glitch();
    pulses = 0;
    pulse(2);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL glitch_counter: got %0d expected 0", bus.counter); end
    pulse(3);
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL gap3_pulses: got %0d expected 1", pulses); end
    n_cmp++;
    if (bus.counter !== 8'd3) begin n_bad++; $display("FAIL gap3_counter: got %0d expected 3", bus.counter); end
  endtask

  task automatic test_latch_zero();
    logic exp_irq;
    wr(MMC3_REG_LATCH, 8'd0);
    wr(MMC3_REG_RELOAD, 8'd0);
    wr(MMC3_REG_ENABLE, 8'd0);
    for (int i = 0; i < 3; i++) begin
      pulse(4);
      n_cmp++;
      if (bus.irq_n !== 1'b0) begin n_bad++; $display("FAIL latch0_irq%0d: got %b expected 0", i, bus.irq_n); end
    end
    wr(MMC3_REG_DISABLE, 8'd0);
    wr(MMC3_REG_ENABLE, 8'd0);
    pulse(4);
`ifdef COOLGIRL_MMC3_ALT_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    n_cmp++;
    if (bus.irq_n !== exp_irq) begin n_bad++; $display("FAIL latch0_noreload_irq: got %b expected %b", bus.irq_n, exp_irq); end
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL latch0_counter: got %0d expected 0", bus.counter); end
  endtask

  task automatic test_simultaneous();
    wr(MMC3_REG_DISABLE, 8'd0);
    wr(MMC3_REG_LATCH, 8'd1);
    wr(MMC3_REG_RELOAD, 8'd0);
    wr(MMC3_REG_ENABLE, 8'd0);
    pulse(4);
    n_cmp++;
    if (bus.counter !== 8'd1) begin n_bad++; $display("FAIL simul_setup: got %0d expected 1", bus.counter); end
    pulse_wr(4, MMC3_REG_DISABLE, 8'd0);
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL dis_step_counter: got %0d expected 0", bus.counter); end
    n_cmp++;
    if (bus.irq_n !== 1'b1) begin n_bad++; $display("FAIL dis_step_irq: got %b expected 1", bus.irq_n); end
    wr(MMC3_REG_LATCH, 8'd0);
    wr(MMC3_REG_RELOAD, 8'd0);
    pulse_wr(4, MMC3_REG_ENABLE, 8'd0);
    n_cmp++;
    if (bus.irq_n !== 1'b1) begin n_bad++; $display("FAIL en_step_irq: got %b expected 1", bus.irq_n); end
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL en_step_counter: got %0d expected 0", bus.counter); end
    pulse_wr(4, MMC3_REG_LATCH, 8'd7);
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL latch_step_old: got %0d expected 0", bus.counter); end
    pulse(4);
    n_cmp++;
    if (bus.counter !== 8'd7) begin n_bad++; $display("FAIL latch_step_new: got %0d expected 7", bus.counter); end
    wr(MMC3_REG_RELOAD, 8'd0);
    pulse_wr(4, MMC3_REG_RELOAD, 8'd0);
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL reload_step_counter: got %0d expected 0", bus.counter); end
    pulse(4);
    n_cmp++;
    if (bus.counter !== 8'd7) begin n_bad++; $display("FAIL reload_step_next: got %0d expected 7", bus.counter); end
  endtask

  task automatic test_reset_mid();
    wr(MMC3_REG_DISABLE, 8'd0);
    wr(MMC3_REG_LATCH, 8'd0);
    wr(MMC3_REG_RELOAD, 8'd0);
    wr(MMC3_REG_ENABLE, 8'd0);
    pulse(4);
    wr(MMC3_REG_LATCH, 8'd6);
    pulse(4);
    pulse(4);
    n_cmp++;
    if (bus.counter !== 8'd5) begin n_bad++; $display("FAIL mid_counter: got %0d expected 5", bus.counter); end
    n_cmp++;
    if (bus.irq_n !== 1'b0) begin n_bad++; $display("FAIL mid_irq: got %b expected 0", bus.irq_n); end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL rst_mid_counter: got %0d expected 0", bus.counter); end
    n_cmp++;
    if (bus.irq_n !== 1'b1) begin n_bad++; $display("FAIL rst_mid_irq: got %b expected 1", bus.irq_n); end
    bus.a12 = 1'b0;
    tick();
    bus.a12 = 1'b1;
    tick();
    reset = 1'b0;
    pulses = 0;
    ticks(6);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL rst_a12_ignored: got %0d expected 0", pulses); end
    pulse(4);
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL rst_post_pulses: got %0d expected 1", pulses); end
    n_cmp++;
    if (bus.counter !== 8'd0) begin n_bad++; $display("FAIL rst_latch_cleared: got %0d expected 0", bus.counter); end
    chk("rst_irq_after", bus.irq_n, 1);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    pulses       = 0;
    reset        = 1'b1;
    bus.a12      = 1'b0;
    bus.reg_we   = 1'b0;
    bus.reg_sel  = 2'd0;
    bus.reg_data = 8'd0;
    test_reset();
    test_count();
    test_glitch();
    test_latch_zero();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
